// File: rtl/count_sched_pkg.sv
// Shared types and defaults for the count scheduler and its arbiter.
package count_sched_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RUN,
        DONE
    } state_e;

    // Pointer width; floored at 1 so a single-requester build still has a legal vector.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PTR_W = ptr_w(DEF_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr_i, wrapping.
module rr_arbiter
    import count_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p,
                                                  input int unsigned     off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[wrap_idx(ptr_i, i)]) begin
                valid_o        = 1'b1;
                idx_o          = wrap_idx(ptr_i, i);
                gnt_o[idx_o]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_scheduler.sv
// Round-robin owner of a shared enable-gated counter: grants one requester,
// enables the counter for its burst length, then reports the count with done.
module count_scheduler
    import count_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    input  logic [WIDTH-1:0]         cnt_value,
    output logic                     cnt_en,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [WIDTH-1:0]         done_count
);

    localparam int unsigned PW = ptr_w(NUM_REQ);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [WIDTH-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   ticks_q, ticks_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               cnt_en_q, cnt_en_d;
    logic               aborted_q, aborted_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            len_q     <= '0;
            ticks_q   <= '0;
            gnt_q     <= '0;
            cnt_en_q  <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            len_q     <= len_d;
            ticks_q   <= ticks_d;
            gnt_q     <= gnt_d;
            cnt_en_q  <= cnt_en_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        len_d     = len_q;
        ticks_d   = ticks_q;
        gnt_d     = gnt_q;
        cnt_en_d  = cnt_en_q;
        aborted_d = aborted_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    win_d   = arb_idx;
                    len_d   = req_len[arb_idx*WIDTH +: WIDTH];
                    ticks_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[win_q]) begin
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_en_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                ticks_d = ticks_q + 1'b1;
                // A burst whose last increment coincides with req dropping counts as complete.
                if (ticks_q + 1'b1 == len_q) begin
                    cnt_en_d = 1'b0;
                    state_d  = DONE;
                end else if (!req[win_q]) begin
                    cnt_en_d  = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                ptr_d     = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                gnt_d     = '0;
                aborted_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_en     = cnt_en_q;
    assign gnt        = gnt_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign done_count = done ? cnt_value : '0;

endmodule

// File: tb/tb_count_scheduler.sv
// Directed and randomized bench for count_scheduler with an external 4-bit counter.
module tb_count_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_len;
    logic [3:0]  cnt_value;
    logic        cnt_en;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [3:0]  done_count;

    int checks = 0;
    int errors = 0;

    int   model_ptr;
    int   model_cnt;
    logic last_was_done;

    count_scheduler #(
        .NUM_REQ (4),
        .WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_len    (req_len),
        .cnt_value  (cnt_value),
        .cnt_en     (cnt_en),
        .gnt        (gnt),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_value <= '0;
        else if (cnt_en) cnt_value <= cnt_value + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) @(negedge clk);
        last_was_done = 1'b0;
    endtask

    // One complete burst; abort_after > 0 drops the winner's req after that many enable cycles.
    task automatic burst(input logic [3:0] r, input logic [15:0] lens, input int abort_after);
        int         w;
        int         l;
        int         exp_inc;
        int         waited;
        int         cyc;
        int         inc;
        logic       found;
        logic [3:0] exp_gnt;
        req     = r;
        req_len = lens;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            if (w < 0 && r[(model_ptr + i) % 4]) w = (model_ptr + i) % 4;
        end
        l       = int'(lens[w*4 +: 4]);
        exp_inc = (abort_after > 0) ? abort_after : l;
        exp_gnt = 4'b0001 << w;

        waited = 0;
        found  = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            waited++;
            if (gnt != '0) found = 1'b1;
        end
        check("grant_seen", 32'(found), 32'd1);
        if (!found) return;
        check("grant_latency", waited, last_was_done ? 2 : 1);
        check("gnt_winner", 32'(gnt), 32'(exp_gnt));
        req_len = 16'($urandom());

        cyc   = 0;
        inc   = 0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            cyc++;
            if (done) found = 1'b1;
            else if (cnt_en) begin
                inc++;
                if (abort_after > 0 && inc == abort_after) req[w] = 1'b0;
            end
        end
        check("done_seen", 32'(found), 32'd1);
        check("cnt_en_cycles", inc, exp_inc);
        check("done_timing", cyc, exp_inc + 1);
        check("done_count", 32'(done_count), (model_cnt + exp_inc) % 16);
        check("aborted", 32'(aborted), (abort_after > 0) ? 1 : 0);
        check("gnt_at_done", 32'(gnt), 32'(exp_gnt));
        check("busy_at_done", 32'(busy), 32'd1);

        model_cnt     = (model_cnt + exp_inc) % 16;
        model_ptr     = (w + 1) % 4;
        last_was_done = 1'b1;
    endtask

    initial begin
        int   l;
        logic found;
        rst_n         = 1'b0;
        req           = '0;
        req_len       = '0;
        model_ptr     = 0;
        model_cnt     = 0;
        last_was_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_aborted", 32'(aborted), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        rst_n = 1'b1;

        // Fairness: all four held with length 2 -> winners 0,1,2,3,0
        for (int i = 0; i < 5; i++) burst(4'b1111, 16'h2222, 0);
        burst(4'b0001, 16'h0005, 0);

        // Steer the counter to 14, then a length-3 burst wraps to 1
        l = (14 - model_cnt + 16) % 16;
        burst(4'b0010, 16'(l << 4), 0);
        burst(4'b0100, 16'h0300, 0);
        check("wrap_count", 32'(done_count), 32'd1);

        burst(4'b0010, 16'h0000, 0);
        burst(4'b1000, 16'hA000, 4);
        burst(4'b1010, 16'h1111, 0);
        idle(3);

        for (int i = 0; i < 25; i++) begin
            burst(4'($urandom_range(1, 15)), 16'($urandom()), 0);
            if ($urandom_range(0, 3) == 0) idle(2);
        end

        // Reset mid-burst with the pointer parked at 1
        idle(2);
        burst(4'b0001, 16'h0003, 0);
        req     = 4'b0010;
        req_len = 16'h00A0;
        found   = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (cnt_en) found = 1'b1;
        end
        check("pre_reset_run", 32'(found), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cnt_en", 32'(cnt_en), 32'd0);
        check("midrst_gnt", 32'(gnt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        model_ptr     = 0;
        model_cnt     = 0;
        last_was_done = 1'b0;
        burst(4'b0011, 16'h0033, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
